// File: rtl/secure_serdes_decryptor_core_pkg.sv
// Shared definitions for the serial XOR encryptor/decryptor pair and its wrapper.
package secure_serdes_decryptor_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DECRYPT = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  localparam int unsigned FRAME_LEN = 8;
  localparam logic [127:0] TEAM_KEY = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

  function automatic logic [7:0] decrypt_byte(input logic [7:0] c, input logic [7:0] b,
                                              input logic [7:0] k);
    return c ^ b ^ k;
  endfunction

endpackage

// File: rtl/secure_serdes_decryptor_core_if.sv
// Receive-side frame bus: serial cipher/B inputs, key, and recovered plaintext outputs.
interface secure_serdes_decryptor_core_if #(parameter int CNT_W = 8);
  logic             start;
  logic [127:0]     key;
  logic             cipher_in;
  logic             b_bit;
  logic             plain_out;
  logic [7:0]       plain_byte;
  logic             byte_valid;
  logic             done;
  logic [CNT_W-1:0] frame_count;

  modport master (
    output start, key, cipher_in, b_bit,
    input  plain_out, plain_byte, byte_valid, done, frame_count
  );

  modport slave (
    input  start, key, cipher_in, b_bit,
    output plain_out, plain_byte, byte_valid, done, frame_count
  );
endinterface

// File: rtl/secure_serdes_decryptor_core_serdes_shift8.sv
// 8-bit MSB-first shift register with parallel load; load has priority over shift.
module serdes_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  input  logic       sin,
  output logic [7:0] q
);

  logic [7:0] q_r;

  // Shift/load register
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 8'h00;
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[6:0], sin};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/secure_serdes_decryptor_core.sv
// Deserialises a cipher/B frame, recovers A = C ^ B ^ key slice and re-serialises it.
module secure_serdes_decryptor_core
  import secure_serdes_decryptor_core_pkg::*;
#(
  parameter int KEY_LSB = 0,
  parameter int CNT_W   = 8
) (
  input logic                         clk,
  input logic                         rst,
  secure_serdes_decryptor_core_if.slave bus
);

  state_e           state_r, state_nxt_s;
  logic [2:0]       bit_cnt_r;
  logic             cap_clr_s, cap_shift_s, pl_load_s, pl_shift_s;
  logic [7:0]       c_q_s, b_q_s, pl_q_s, plain_s;
  logic             plain_out_r, byte_valid_r, done_r;
  logic [7:0]       plain_byte_r;
  logic [CNT_W-1:0] frame_count_r;

  // Key is only consulted while DECRYPT loads the plaintext register
  assign plain_s = decrypt_byte(c_q_s, b_q_s, bus.key[KEY_LSB +: 8]);

  serdes_shift8 u_c_reg (.clk(clk), .rst(rst), .load(cap_clr_s), .shift(cap_shift_s),
                         .din(8'h00), .sin(bus.cipher_in), .q(c_q_s));
  serdes_shift8 u_b_reg (.clk(clk), .rst(rst), .load(cap_clr_s), .shift(cap_shift_s),
                         .din(8'h00), .sin(bus.b_bit), .q(b_q_s));
  serdes_shift8 u_p_reg (.clk(clk), .rst(rst), .load(pl_load_s), .shift(pl_shift_s),
                         .din(plain_s), .sin(1'b0), .q(pl_q_s));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_nxt_s = state_r;
    cap_clr_s   = 1'b0;
    cap_shift_s = 1'b0;
    pl_load_s   = 1'b0;
    pl_shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          cap_clr_s   = 1'b1;
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        cap_shift_s = 1'b1;
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s = ST_DECRYPT;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DECRYPT: begin
        pl_load_s   = 1'b1;
        state_nxt_s = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        pl_shift_s = 1'b1;
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r     <= 3'd0;
      plain_out_r   <= 1'b0;
      plain_byte_r  <= 8'h00;
      byte_valid_r  <= 1'b0;
      done_r        <= 1'b0;
      frame_count_r <= {CNT_W{1'b0}};
    end else begin
      byte_valid_r <= pl_load_s;
      if (cap_clr_s || pl_load_s) begin
        bit_cnt_r <= 3'd0;
      end else if (cap_shift_s || pl_shift_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (cap_clr_s) begin
        done_r <= 1'b0;
      end else if (pl_shift_s && (bit_cnt_r == 3'd7)) begin
        done_r        <= 1'b1;
        frame_count_r <= frame_count_r + CNT_W'(1);
      end
      if (pl_load_s) begin
        plain_byte_r <= plain_s;
      end
      if (pl_shift_s) begin
        plain_out_r <= pl_q_s[7];
      end
    end
  end

  assign bus.plain_out   = plain_out_r;
  assign bus.plain_byte  = plain_byte_r;
  assign bus.byte_valid  = byte_valid_r;
  assign bus.done        = done_r;
  assign bus.frame_count = frame_count_r;

endmodule

// File: tb/tb_secure_serdes_decryptor_core.sv
// Scoreboard bench: stimulus pushes expected plaintext frames, a monitor checks the DUT output stream.
module tb_secure_serdes_decryptor_core;
  import secure_serdes_decryptor_core_pkg::*;

  typedef struct {
    logic [7:0] plain;
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   issued = 0;
  int   seen = 0;
  logic [7:0] model_frames = 8'd0;
  exp_t sb[$];

  secure_serdes_decryptor_core_if #(.CNT_W(8)) bus ();

  secure_serdes_decryptor_core #(.KEY_LSB(0), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_plain_out"}, {31'd0, bus.plain_out}, 32'd0);
    check({name, "_plain_byte"}, {24'd0, bus.plain_byte}, 32'd0);
    check({name, "_byte_valid"}, {31'd0, bus.byte_valid}, 32'd0);
    check({name, "_done"}, {31'd0, bus.done}, 32'd0);
    check({name, "_frame_count"}, {24'd0, bus.frame_count}, 32'd0);
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the final OUTPUT edge.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] b, input logic [7:0] exp_plain,
                            input bit spam, input bit key_churn);
    exp_t e;
    bus.start = 1'b1;
    @(posedge clk); #1;
    model_frames = model_frames + 8'd1;
    e.plain = exp_plain;
    e.cyc   = cyc + 9;
    e.cnt   = model_frames;
    sb.push_back(e);
    issued++;
    for (int i = 7; i >= 0; i--) begin
      bus.start     = spam ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.cipher_in = c[i];
      bus.b_bit     = b[i];
      @(posedge clk); #1;
    end
    for (int i = 0; i < 9; i++) begin
      bus.start     = spam ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.cipher_in = 1'($urandom_range(1, 0));
      bus.b_bit     = 1'($urandom_range(1, 0));
      if (key_churn && i > 0) bus.key = {$urandom, $urandom, $urandom, $urandom};
      if (spam && i == 8) bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  // Output monitor: pops expectations whenever byte_valid is seen
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.byte_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte_valid: got pulse with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("plain_byte", {24'd0, bus.plain_byte}, {24'd0, e.plain});
          check("byte_valid_cycle", cyc, e.cyc);
          check("done_low_in_frame", {31'd0, bus.done}, 32'd0);
          for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check("plain_out", {31'd0, bus.plain_out}, {31'd0, e.plain[i]});
            if (i == 7) check("byte_valid_one_cycle", {31'd0, bus.byte_valid}, 32'd0);
            if (i == 1) check("done_not_early", {31'd0, bus.done}, 32'd0);
            if (i == 0) begin
              check("done_with_last_bit", {31'd0, bus.done}, 32'd1);
              check("frame_count", {24'd0, bus.frame_count}, {24'd0, e.cnt});
            end
          end
          seen++;
        end
      end
    end
  end

  initial begin
    logic [7:0] a, b, k;
    bus.start = 1'b0;
    bus.key = TEAM_KEY;
    bus.cipher_in = 1'b0;
    bus.b_bit = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    repeat (20) begin
      @(posedge clk); #1;
      check_all_zero("idle");
    end

    send_frame(8'hAD, 8'h3C, 8'hA5, 1'b0, 1'b0);
    send_frame(8'h34, 8'h00, 8'h00, 1'b0, 1'b0);
    send_frame(8'hCB, 8'hFF, 8'h00, 1'b0, 1'b0);

    // start spam in CAPTURE/OUTPUT, including on the final OUTPUT edge
    for (int n = 0; n < 4; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      send_frame(a ^ b ^ 8'h34, b, a, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    check("done_sticky_idle", {31'd0, bus.done}, 32'd1);
    repeat (12) @(posedge clk);
    #1;

    // reset in the middle of capture
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cipher_in = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_frames = 8'd0;
    check_all_zero("mid_frame_reset");
    repeat (12) begin
      @(posedge clk); #1;
      check("no_output_after_abort", {31'd0, bus.byte_valid}, 32'd0);
    end
    send_frame(8'hAD, 8'h3C, 8'hA5, 1'b0, 1'b0);

    // loopback against a behavioural encryptor with random keys
    for (int n = 0; n < 300; n++) begin
      bus.key = {$urandom, $urandom, $urandom, $urandom};
      k = bus.key[7:0];
      a = 8'($urandom);
      b = 8'($urandom);
      send_frame(a ^ b ^ k, b, a, 1'($urandom_range(1, 0)), 1'b1);
    end

    for (int t = 0; t < 50 && seen < issued; t++) @(posedge clk);
    @(negedge clk);
    check("all_frames_seen", seen, issued);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
